// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer in front of the CSR register file.
// Absorbs the file's one-cycle registered read and returns the pre-modification value.
module csr_access_unit #(
  parameter int WORD_LEN      = 32,
  parameter int REG_ADDR_SIZE = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic [REG_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_LEN-1:0]      req_src,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WORD_LEN-1:0]      resp_rdata,
  output logic                     resp_illegal,
  output logic [REG_ADDR_SIZE-1:0] csr_addr,
  input  logic [WORD_LEN-1:0]      csr_rdata,
  output logic                     csr_wen,
  output logic [WORD_LEN-1:0]      csr_wdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_MODIFY = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic [REG_ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_LEN-1:0]        src_q, src_d;
  logic [WORD_LEN-1:0]        resp_rdata_q, resp_rdata_d;
  logic                       resp_illegal_q, resp_illegal_d;

  logic                       funct3_bad_s;
  logic                       wr_req_s;
  logic                       illegal_s;
  logic                       write_ok_s;
  logic [WORD_LEN-1:0]        modified_s;

  // funct3[1:0]: 01 write, 10 set bits, 11 clear bits
  function automatic logic [WORD_LEN-1:0] apply_op(
    input logic [1:0]          op,
    input logic [WORD_LEN-1:0] old_val,
    input logic [WORD_LEN-1:0] src_val
  );
    logic [WORD_LEN-1:0] res;
    case (op)
      2'b01:   res = src_val;
      2'b10:   res = old_val | src_val;
      2'b11:   res = old_val & ~src_val;
      default: res = src_val;
    endcase
    return res;
  endfunction

  // Decode of the latched request: write intent, legality and new value
  always_comb begin
    funct3_bad_s = (funct3_q[1:0] == 2'b00);
    wr_req_s     = (funct3_q[1:0] == 2'b01) || (src_q != {WORD_LEN{1'b0}});
    illegal_s    = funct3_bad_s ||
                   (wr_req_s && (addr_q[REG_ADDR_SIZE-1 -: 2] == 2'b11));
    write_ok_s   = wr_req_s && !illegal_s;
    modified_s   = apply_op(funct3_q[1:0], csr_rdata, src_q);
  end

  // Next-state and CSR-port control
  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    src_d          = src_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    csr_wen        = 1'b0;
    csr_wdata      = {WORD_LEN{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          src_d    = req_src;
          state_d  = S_READ;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_MODIFY;
      end
      S_MODIFY: begin
        // csr_rdata is the registered read of addr_q presented during READ
        csr_wen        = write_ok_s;
        csr_wdata      = write_ok_s ? modified_s : {WORD_LEN{1'b0}};
        resp_rdata_d   = illegal_s ? {WORD_LEN{1'b0}} : csr_rdata;
        resp_illegal_d = illegal_s;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      funct3_q       <= 3'b000;
      addr_q         <= {REG_ADDR_SIZE{1'b0}};
      src_q          <= {WORD_LEN{1'b0}};
      resp_rdata_q   <= {WORD_LEN{1'b0}};
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      src_q          <= src_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
  assign csr_addr     = addr_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomised and directed bench for csr_access_unit with a CSR file model
// and an architectural reference of Zicsr read-modify-write behaviour.
module tb_csr_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;

  logic        preload_en;
  logic [11:0] preload_addr;
  logic [31:0] preload_data;

  logic [31:0] file_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];
  logic [11:0] pool     [0:7];

  int n_cmp;
  int n_bad;

  csr_access_unit #(.WORD_LEN(32), .REG_ADDR_SIZE(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_addr     (csr_addr),
    .csr_rdata    (csr_rdata),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: registered read, synchronous write, bench preload port
  always @(posedge clk) begin
    csr_rdata <= file_mem[csr_addr];
    if (preload_en) file_mem[preload_addr] <= preload_data;
    else if (csr_wen) file_mem[csr_addr] <= csr_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    preload_en   = 1'b1;
    preload_addr = a;
    preload_data = v;
    ref_mem[a]   = v;
    @(negedge clk);
    preload_en   = 1'b0;
  endtask

  // One full request; expected values come from the architectural rules
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                        input int hold, input bit poke);
    logic [31:0] old_v, new_v, exp_rdata, got_a, got_d;
    bit is_write_form, is_set_form, legal_f3, wants_write, illegal, do_write;
    int cycles, wen_cnt;
    old_v         = ref_mem[a];
    legal_f3      = !(f3 == 3'd0 || f3 == 3'd4);
    is_write_form = (f3 == 3'd1 || f3 == 3'd5);
    is_set_form   = (f3 == 3'd2 || f3 == 3'd6);
    wants_write   = is_write_form || (s != 32'd0);
    illegal       = !legal_f3 || (wants_write && a >= 12'hC00);
    do_write      = !illegal && wants_write;
    if (is_write_form)    new_v = s;
    else if (is_set_form) new_v = old_v | s;
    else                  new_v = old_v & ~s;
    exp_rdata = illegal ? 32'd0 : old_v;
    if (do_write) ref_mem[a] = new_v;

    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = a;
    req_src    = s;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_src   = $urandom();
    cycles  = 1;
    wen_cnt = 0;
    got_a   = 32'd0;
    got_d   = 32'd0;
    while (!resp_valid && cycles < 8) begin
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (csr_wen) begin
        wen_cnt++;
        got_a = 32'(csr_addr);
        got_d = csr_wdata;
      end
      @(negedge clk);
      cycles++;
    end
    chk("resp_latency", 32'(cycles), 32'd3);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_illegal", 32'(resp_illegal), 32'(illegal));
    if (csr_wen) wen_cnt++;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid  = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = a;
        req_src    = $urandom();
      end
      @(negedge clk);
      if (csr_wen) wen_cnt++;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rdata);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle_ready", 32'(req_ready), 32'd1);
    chk("back_idle_valid", 32'(resp_valid), 32'd0);
    chk("wen_pulses", 32'(wen_cnt), 32'(do_write));
    if (do_write) begin
      chk("wen_addr", got_a, 32'(a));
      chk("wen_data", got_d, new_v);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] s;
    int wen_seen;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 12'd0;
    req_src = 32'd0;
    resp_ready = 1'b0;
    preload_en = 1'b0;
    preload_addr = 12'd0;
    preload_data = 32'd0;
    pool[0] = 12'h340; pool[1] = 12'h300; pool[2] = 12'h305; pool[3] = 12'h341;
    pool[4] = 12'hC00; pool[5] = 12'hC01; pool[6] = 12'hF14; pool[7] = 12'h7C0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_illegal", 32'(resp_illegal), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_csr_wen", 32'(csr_wen), 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_csr_addr", 32'(csr_addr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) set_csr(pool[i], $urandom());
    set_csr(12'h340, 32'hDEADBEEF);
    set_csr(12'h300, 32'h00000008);
    set_csr(12'hC00, 32'h00000005);

    run_op(3'd1, 12'h340, 32'h12345678, 0, 1'b0);
    run_op(3'd2, 12'h300, 32'h00000080, 0, 1'b0);
    run_op(3'd3, 12'h300, 32'h00000008, 0, 1'b0);
    run_op(3'd2, 12'hC00, 32'h00000000, 0, 1'b0);
    run_op(3'd1, 12'hC00, 32'h00000001, 0, 1'b0);
    run_op(3'd4, 12'h305, 32'h0000FFFF, 0, 1'b0);
    run_op(3'd0, 12'h305, 32'h00000001, 1, 1'b0);
    run_op(3'd6, 12'h305, 32'h00000011, 0, 1'b0);
    run_op(3'd1, 12'h341, 32'hA5A5A5A5, 5, 1'b1);

    // Reset while the unit is in READ
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'd1;
    req_addr   = 12'h341;
    req_src    = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_phase_wen", 32'(csr_wen), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    wen_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (csr_wen || resp_valid) wen_seen++;
      @(negedge clk);
    end
    chk("midrst_quiet", 32'(wen_seen), 32'd0);
    run_op(3'd1, 12'h341, 32'h13579BDF, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) s = 32'd0;
      else if (f3[2]) s = 32'($urandom_range(0, 31));
      else s = $urandom();
      run_op(f3, a, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
